// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register with two-entry skid buffer, flush and stall counter
module ex_mem_stage #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_result,
    input  logic          in_zero,
    input  logic [4:0]    in_rd,
    input  logic          in_reg_write,
    input  logic          in_mem_read,
    input  logic          in_mem_write,
    input  logic [DW-1:0] in_store_data,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_result,
    output logic          out_zero,
    output logic [4:0]    out_rd,
    output logic          out_reg_write,
    output logic          out_mem_read,
    output logic          out_mem_write,
    output logic [DW-1:0] out_store_data,
    output logic [CW-1:0] stall_cnt
);

    localparam int EW = 2 * DW + 9;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_t;

    state_t        state;
    logic [EW-1:0] main_q;
    logic [EW-1:0] skid_q;
    logic [EW-1:0] in_entry;
    logic          in_xfer;
    logic          out_xfer;

    assign in_entry = {in_result, in_zero, in_rd, in_reg_write,
                       in_mem_read, in_mem_write, in_store_data};
    assign {out_result, out_zero, out_rd, out_reg_write,
            out_mem_read, out_mem_write, out_store_data} = main_q;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // in_ready and out_valid are registered alongside the state so in_ready
    // never depends combinationally on out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            main_q    <= '0;
            skid_q    <= '0;
        end else if (flush) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        main_q    <= in_entry;
                        state     <= ONE;
                        out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_q <= in_entry;
                    end else if (in_xfer) begin
                        skid_q   <= in_entry;
                        state    <= TWO;
                        in_ready <= 1'b0;
                    end else if (out_xfer) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        main_q   <= skid_q;
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Back-pressure counter is deliberately independent of flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CW{1'b1}})) begin
            stall_cnt <= stall_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - randomized self-checking bench for ex_mem_stage against a queue model
module tb_ex_mem_stage;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_result;
    logic          in_zero;
    logic [4:0]    in_rd;
    logic          in_reg_write;
    logic          in_mem_read;
    logic          in_mem_write;
    logic [DW-1:0] in_store_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_result;
    logic          out_zero;
    logic [4:0]    out_rd;
    logic          out_reg_write;
    logic          out_mem_read;
    logic          out_mem_write;
    logic [DW-1:0] out_store_data;
    logic [CW-1:0] stall_cnt;

    typedef struct packed {
        logic [DW-1:0] result;
        logic          zero;
        logic [4:0]    rd;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
        logic [DW-1:0] store_data;
    } ent_t;

    ent_t q[$];
    bit   m_ready;
    int   m_stall;
    int   vectors = 0;
    int   miscompares = 0;
    ent_t out_bus;

    assign out_bus = {out_result, out_zero, out_rd, out_reg_write,
                      out_mem_read, out_mem_write, out_store_data};

    always #5 clk = ~clk;

    ex_mem_stage #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_zero(in_zero), .in_rd(in_rd),
        .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
        .in_mem_write(in_mem_write), .in_store_data(in_store_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_store_data(out_store_data),
        .stall_cnt(stall_cnt)
    );

    function automatic ent_t rnd_ent();
        ent_t e;
        e.result     = $urandom;
        e.zero       = 1'($urandom);
        e.rd         = 5'($urandom);
        e.reg_write  = 1'($urandom);
        e.mem_read   = 1'($urandom);
        e.mem_write  = 1'($urandom);
        e.store_data = $urandom;
        return e;
    endfunction

    // Drive one cycle from a negedge, advance the model, return at the next negedge.
    task automatic drive(input ent_t e, input logic iv, input logic fl, input logic ordy);
        bit ix, ox;
        in_valid      = iv;
        in_result     = e.result;
        in_zero       = e.zero;
        in_rd         = e.rd;
        in_reg_write  = e.reg_write;
        in_mem_read   = e.mem_read;
        in_mem_write  = e.mem_write;
        in_store_data = e.store_data;
        flush         = fl;
        out_ready     = ordy;
        ix = iv && m_ready;
        ox = (q.size() > 0) && ordy;
        if (q.size() > 0 && !ordy && m_stall < 15) m_stall++;
        if (ox) void'(q.pop_front());
        if (fl) q.delete();
        else if (ix) q.push_back(e);
        m_ready = (q.size() < 2);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        q.delete(); m_ready = 1'b1; m_stall = 0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(rnd_ent(), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        q.delete(); m_ready = 1'b1; m_stall = 0;
        vectors += 4;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        if (out_result !== '0) begin miscompares++; $display("FAIL reset_out_result got %h exp 0", out_result); end
        if (stall_cnt !== '0) begin miscompares++; $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt); end
        rst_n = 1'b1;
    endtask

    task automatic test_streaming();
        ent_t e;
        for (int i = 1; i <= 8; i++) begin
            e = rnd_ent();
            e.result = DW'(i);
            drive(e, 1'b1, 1'b0, 1'b1);
            vectors += 3;
            if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid[%0d] got %b exp 1", i, out_valid); end
            if (out_result !== DW'(i)) begin miscompares++; $display("FAIL stream_result[%0d] got %h exp %h", i, out_result, i); end
            if (out_bus !== e) begin miscompares++; $display("FAIL stream_entry[%0d] got %h exp %h", i, out_bus, e); end
        end
        drive(rnd_ent(), 1'b0, 1'b0, 1'b1);
        vectors += 2;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_drain got %b exp 0", out_valid); end
        if (stall_cnt !== '0) begin miscompares++; $display("FAIL stream_stall got %0d exp 0", stall_cnt); end
    endtask

    task automatic test_skid();
        ent_t a, b, c;
        do_reset();
        a = rnd_ent(); a.result = 32'hA;
        b = rnd_ent(); b.result = 32'hB;
        c = rnd_ent(); c.result = 32'hC;
        drive(a, 1'b1, 1'b0, 1'b0);
        vectors += 3;
        if (out_result !== 32'hA) begin miscompares++; $display("FAIL skid_head_a got %h exp a", out_result); end
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL skid_ready_a got %b exp 1", in_ready); end
        if (stall_cnt !== 4'd0) begin miscompares++; $display("FAIL skid_stall_a got %0d exp 0", stall_cnt); end
        drive(b, 1'b1, 1'b0, 1'b0);
        vectors += 2;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL skid_ready_b got %b exp 0", in_ready); end
        if (stall_cnt !== 4'd1) begin miscompares++; $display("FAIL skid_stall_b got %0d exp 1", stall_cnt); end
        drive(c, 1'b1, 1'b0, 1'b0);
        vectors += 3;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL skid_ready_c got %b exp 0", in_ready); end
        if (out_result !== 32'hA) begin miscompares++; $display("FAIL skid_hold_a got %h exp a", out_result); end
        if (stall_cnt !== 4'd2) begin miscompares++; $display("FAIL skid_stall_c got %0d exp 2", stall_cnt); end
        drive(c, 1'b1, 1'b0, 1'b1);
        vectors += 2;
        if (out_bus !== b) begin miscompares++; $display("FAIL skid_head_b got %h exp %h", out_bus, b); end
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL skid_resume_ready got %b exp 1", in_ready); end
        drive(c, 1'b1, 1'b0, 1'b1);
        vectors += 1;
        if (out_bus !== c) begin miscompares++; $display("FAIL skid_head_c got %h exp %h", out_bus, c); end
        drive(c, 1'b0, 1'b0, 1'b1);
        vectors += 2;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL skid_empty got %b exp 0", out_valid); end
        if (stall_cnt !== 4'd2) begin miscompares++; $display("FAIL skid_stall_end got %0d exp 2", stall_cnt); end
    endtask

    task automatic test_flush();
        ent_t d;
        do_reset();
        drive(rnd_ent(), 1'b1, 1'b0, 1'b0);
        drive(rnd_ent(), 1'b1, 1'b0, 1'b0);
        d = rnd_ent(); d.result = 32'hD;
        drive(d, 1'b1, 1'b1, 1'b0);
        vectors += 3;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid got %b exp 0", out_valid); end
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_ready got %b exp 1", in_ready); end
        if (stall_cnt !== 4'd2) begin miscompares++; $display("FAIL flush_stall got %0d exp 2", stall_cnt); end
        for (int i = 0; i < 3; i++) begin
            drive(rnd_ent(), 1'b0, 1'b0, 1'b1);
            vectors++;
            if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_leak[%0d] got valid %b result %h", i, out_valid, out_result); end
        end
    endtask

    task automatic test_sideband();
        ent_t e;
        e = '0;
        e.result = 32'h1234_5678; e.zero = 1'b1; e.rd = 5'd31;
        e.mem_write = 1'b1; e.store_data = 32'hDEAD_BEEF;
        drive(e, 1'b1, 1'b0, 1'b1);
        vectors += 7;
        if (out_result !== 32'h1234_5678) begin miscompares++; $display("FAIL sb_result got %h exp 12345678", out_result); end
        if (out_zero !== 1'b1) begin miscompares++; $display("FAIL sb_zero got %b exp 1", out_zero); end
        if (out_rd !== 5'd31) begin miscompares++; $display("FAIL sb_rd got %0d exp 31", out_rd); end
        if (out_mem_write !== 1'b1) begin miscompares++; $display("FAIL sb_mem_write got %b exp 1", out_mem_write); end
        if (out_mem_read !== 1'b0) begin miscompares++; $display("FAIL sb_mem_read got %b exp 0", out_mem_read); end
        if (out_reg_write !== 1'b0) begin miscompares++; $display("FAIL sb_reg_write got %b exp 0", out_reg_write); end
        if (out_store_data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL sb_store got %h exp deadbeef", out_store_data); end
        drive(e, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_saturation();
        do_reset();
        drive(rnd_ent(), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            drive(rnd_ent(), 1'b0, 1'b0, 1'b0);
            vectors++;
            if (stall_cnt !== 4'(m_stall)) begin miscompares++; $display("FAIL sat_cnt[%0d] got %0d exp %0d", i, stall_cnt, m_stall); end
        end
        vectors++;
        if (stall_cnt !== 4'd15) begin miscompares++; $display("FAIL sat_final got %0d exp 15", stall_cnt); end
    endtask

    task automatic test_async_reset();
        ent_t e;
        do_reset();
        e = rnd_ent(); e.result = 32'h5A5A_0001;
        drive(e, 1'b1, 1'b0, 1'b0);
        drive(rnd_ent(), 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        vectors += 4;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL async_valid got %b exp 0", out_valid); end
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL async_ready got %b exp 1", in_ready); end
        if (out_result !== '0) begin miscompares++; $display("FAIL async_result got %h exp 0", out_result); end
        if (stall_cnt !== '0) begin miscompares++; $display("FAIL async_stall got %0d exp 0", stall_cnt); end
        @(negedge clk);
        q.delete(); m_ready = 1'b1; m_stall = 0;
        rst_n = 1'b1;
        e.result = 32'h5A5A_0002;
        drive(e, 1'b1, 1'b0, 1'b1);
        vectors++;
        if (out_bus !== e) begin miscompares++; $display("FAIL async_restart got %h exp %h", out_bus, e); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(rnd_ent(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 2) != 0));
            vectors += 3;
            if (in_ready !== m_ready) begin miscompares++; $display("FAIL rnd_ready[%0d] got %b exp %b", i, in_ready, m_ready); end
            if (out_valid !== (q.size() > 0)) begin miscompares++; $display("FAIL rnd_valid[%0d] got %b exp %0d", i, out_valid, q.size()); end
            if (stall_cnt !== 4'(m_stall)) begin miscompares++; $display("FAIL rnd_stall[%0d] got %0d exp %0d", i, stall_cnt, m_stall); end
            if (q.size() > 0) begin
                vectors++;
                if (out_bus !== q[0]) begin miscompares++; $display("FAIL rnd_entry[%0d] got %h exp %h", i, out_bus, q[0]); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_result = '0; in_zero = 1'b0; in_rd = '0; in_reg_write = 1'b0;
        in_mem_read = 1'b0; in_mem_write = 1'b0; in_store_data = '0;
        q.delete(); m_ready = 1'b1; m_stall = 0;
        @(negedge clk);
        test_reset();
        test_streaming();
        test_skid();
        test_flush();
        test_sideband();
        test_saturation();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute-to-memory pipeline stage that captures the ALU's 32-bit result and zero flag, together with the instruction's destination and memory-control sideband, and hands them to the memory/writeback stage. It uses a valid/ready handshake with a two-entry skid buffer, so `in_ready` is a registered signal and never depends combinationally on `out_ready`. It also supports a synchronous flush for branch redirects and keeps a saturating back-pressure counter for performance debug.

## Interface
Parameters:
- `DW`, 32, data width of the ALU result and store data
- `CW`, 16, width of the back-pressure counter

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous reset, active-low
- `in_valid`  in  1  execute stage presents a valid ALU result
- `in_ready`  out  1  stage can accept this cycle (registered)
- `in_result`  in  DW  ALU `result`
- `in_zero`  in  1  ALU `zero` flag
- `in_rd`  in  5  destination register index
- `in_reg_write`  in  1  writeback enable
- `in_mem_read`  in  1  load
- `in_mem_write`  in  1  store
- `in_store_data`  in  DW  store operand (rs2 value)
- `flush`  in  1  synchronous kill of all held and incoming entries
- `out_valid`  out  1  entry presented to memory stage
- `out_ready`  in  1  memory stage accepts
- `out_result`, `out_zero`, `out_rd`, `out_reg_write`, `out_mem_read`, `out_mem_write`, `out_store_data`  out  as inputs  registered fields of the head entry
- `stall_cnt`  out  CW  cycles with `out_valid & !out_ready`, saturating

## Operation
- An input transfer occurs when `in_valid & in_ready`. An output transfer occurs when `out_valid & out_ready`.
- Storage consists of a main register, which drives the outputs, and a skid register. The state machine has three states: EMPTY, ONE, TWO.
- EMPTY: input transfer loads main and moves to ONE.
- ONE, by input/output transfer:
  - in&out: load main with the new entry; stay in ONE.
  - in only: load skid; go to TWO.
  - out only: go to EMPTY.
  - neither: hold.
- TWO: output transfer copies skid to main and moves to ONE. No input transfer is possible in TWO.
- `in_ready` = 1 in EMPTY and ONE, 0 in TWO. It is registered and updated together with the state.
- `out_valid` = 1 in ONE and TWO.
- Flush has priority over everything in the same cycle. The next state is EMPTY, any concurrent input is discarded, and `in_ready` becomes 1. An output transfer that occurs in the flush cycle still counts as delivered downstream.
- Data fields are not cleared on flush. Only the valid state is cleared.
- `stall_cnt` increments in every cycle where `out_valid & !out_ready`, saturates at all-ones, is unaffected by flush, and clears only on reset.
- Fields are passed through bit-exact. The stage does no arithmetic and does not recompute `zero`.
- Entry order is strictly FIFO. No entry is duplicated or dropped except by flush.

## Timing
- Reset (while `rst_n` = 0, asynchronous):
  - state = EMPTY, `in_ready` = 1, `out_valid` = 0
  - all `out_*` data fields = 0, `stall_cnt` = 0
- Latency: an entry accepted at edge N appears on `out_*` with `out_valid` = 1 in the cycle after edge N.
- Throughput: 1 entry per cycle when `out_ready` is held at 1.
- Back-pressure: after `out_ready` drops, one further input is absorbed into skid, then `in_ready` = 0 from the next cycle.
- Resume: `out_ready` returning to 1 in TWO drains one entry. `in_ready` returns to 1 the following cycle.
- Reset asserted mid-operation discards all entries immediately. Operation restarts from EMPTY on the first edge after `rst_n` rises.

## Test plan
- Reset with `rst_n` = 0 for 3 cycles and all inputs random -> `in_ready` = 1, `out_valid` = 0, `out_result` = 0, `stall_cnt` = 0.
- Streaming: send results 0x1..0x8 back-to-back with `out_ready` = 1 -> outputs 0x1..0x8 in order, one per cycle, 1-cycle latency, `stall_cnt` = 0.
- Skid: send 0xA, 0xB, 0xC on consecutive cycles with `out_ready` = 0 -> 0xA and 0xB accepted, `in_ready` = 0 while 0xC is held, `stall_cnt` increments each cycle. Raising `out_ready` -> output order 0xA, 0xB, 0xC with no loss.
- Flush in TWO with `in_valid` = 1 (0xD) -> next cycle `out_valid` = 0, `in_ready` = 1, and 0xD is never output.
- Sideband: `in_rd` = 5'd31, `mem_write` = 1, `store_data` = 0xDEADBEEF, `zero` = 1 -> identical values on `out_*`.
- Saturation with `CW` = 4: hold `out_valid` = 1 and `out_ready` = 0 for 20 cycles -> `stall_cnt` stops at 15.
